decim_accumulator: RTL and testbench

// - Windowed sample accumulator for the LPDAQ decimation path. Sits directly downstream of counter.
// - Sums signed input samples over one window; the window is closed by counter's co pulse on tick.
// - Hands the window sum and its sample count downstream over a valid/ready interface.
// - Records an overrun when a window result cannot be delivered.

---
 rtl/lpdaq_pkg.sv | 24 ++
 rtl/decim_out_slot.sv | 97 +++++++++
 rtl/decim_accumulator.sv | 100 ++++++++++
 tb/tb_decim_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lpdaq_pkg.sv
// Shared types and helpers for the LPDAQ decimation path.
package lpdaq_pkg;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  localparam int unsigned FN_W = 32;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [FN_W-1:0] sat_inc(input logic [FN_W-1:0] cnt,
                                              input int unsigned     width);
    logic [FN_W:0] lim;
    lim = (33'd1 << width) - 33'd1;
    if ({1'b0, cnt} >= lim) return lim[FN_W-1:0];
    return cnt + 32'd1;
  endfunction

  // Arithmetic right shift with round-half-up.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] sum,
                                                     input int unsigned        sh);
    if (sh == 0) return sum;
    return (sum + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/decim_out_slot.sv
// Single-entry output holding slot: valid/ready handoff of window results plus sticky overrun.
// Optional average field present when DECIM_ACC_AVG_EN is defined.
module decim_out_slot
  import lpdaq_pkg::*;
#(
  parameter int unsigned OW = 22,
  parameter int unsigned CW = 7
`ifdef DECIM_ACC_AVG_EN
  , parameter int unsigned AW = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic signed [OW-1:0] sum_i,
  input  logic [CW-1:0]        cnt_i,
`ifdef DECIM_ACC_AVG_EN
  input  logic signed [AW-1:0] avg_i,
  output logic signed [AW-1:0] out_avg_o,
`endif
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic signed [OW-1:0] out_data_o,
  output logic [CW-1:0]        out_cnt_o,
  output logic                 overrun_o
);

  out_state_e          state_q, state_d;
  logic                load_c;
  logic                set_ovr_c;
  logic signed [OW-1:0] data_q;
  logic [CW-1:0]       cnt_q;
  logic                ovr_q;
`ifdef DECIM_ACC_AVG_EN
  logic signed [AW-1:0] avg_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A tick while full either replaces the delivered result or is dropped.
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    set_ovr_c = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (tick_i) begin
          load_c  = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (tick_i) begin
          if (out_ready_i) load_c = 1'b1;
          else             set_ovr_c = 1'b1;
        end else if (out_ready_i) begin
          state_d = OUT_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
`ifdef DECIM_ACC_AVG_EN
      avg_q  <= '0;
`endif
    end else begin
      if (load_c) begin
        data_q <= sum_i;
        cnt_q  <= cnt_i;
`ifdef DECIM_ACC_AVG_EN
        avg_q  <= avg_i;
`endif
      end
      if (set_ovr_c) ovr_q <= 1'b1;
    end
  end

  assign out_valid_o = (state_q == OUT_FULL);
  assign out_data_o  = data_q;
  assign out_cnt_o   = cnt_q;
  assign overrun_o   = ovr_q;
`ifdef DECIM_ACC_AVG_EN
  assign out_avg_o   = avg_q;
`endif

endmodule

// File: rtl/decim_accumulator.sv
// Windowed signed sample accumulator; window closed by tick, result handed off via valid/ready.
// Define DECIM_ACC_AVG_EN to add the rounded, clamped per-window average output out_avg.
module decim_accumulator
  import lpdaq_pkg::*;
#(
  parameter  int unsigned DW = 16,
  parameter  int unsigned N  = 64,
  localparam int unsigned CW = $clog2(N) + 1,
  localparam int unsigned OW = DW + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 tick,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic [CW-1:0]        out_cnt,
`ifdef DECIM_ACC_AVG_EN
  output logic signed [DW-1:0] out_avg,
`endif
  output logic                 overrun
);

  logic signed [OW-1:0] acc_q, acc_d;
  logic signed [OW-1:0] sample_ext_c;
  logic signed [OW-1:0] sum_c;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        n_c;

  // The tick-cycle sample is folded into the closing window.
  assign sample_ext_c = in_valid ? OW'(in_data) : '0;
  assign sum_c        = acc_q + sample_ext_c;
  assign n_c          = in_valid ? CW'(sat_inc(32'(cnt_q), CW)) : cnt_q;

  always_comb begin
    acc_d = sum_c;
    cnt_d = n_c;
    if (tick) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef DECIM_ACC_AVG_EN
  localparam int unsigned SH = $clog2(N);
  localparam logic signed [63:0] AVG_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam logic signed [63:0] AVG_MIN = -(64'sd1 <<< (DW - 1));

  if (N == 0 || (N & (N - 1)) != 0) begin : g_n_pow2_check
    $error("decim_accumulator: N must be a power of 2 when the average output is enabled");
  end

  logic signed [63:0]   avg_wide_c;
  logic signed [DW-1:0] avg_c;

  // Saturate the rounded mean into the sample range.
  always_comb begin
    avg_wide_c = round_shift(64'(sum_c), SH);
    avg_c      = DW'(avg_wide_c);
    if (avg_wide_c > AVG_MAX)      avg_c = DW'(AVG_MAX);
    else if (avg_wide_c < AVG_MIN) avg_c = DW'(AVG_MIN);
  end
`endif

  decim_out_slot #(
    .OW (OW),
    .CW (CW)
`ifdef DECIM_ACC_AVG_EN
    , .AW (DW)
`endif
  ) u_out_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick),
    .sum_i       (sum_c),
    .cnt_i       (n_c),
`ifdef DECIM_ACC_AVG_EN
    .avg_i       (avg_c),
    .out_avg_o   (out_avg),
`endif
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_cnt_o   (out_cnt),
    .overrun_o   (overrun)
  );

endmodule

// File: tb/tb_decim_accumulator.sv
// Self-checking bench for decim_accumulator (DW=8, N=4) with a window-tick counter model.
module tb_decim_accumulator;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned OW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 tick;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [CW-1:0]        out_cnt;
  logic                 overrun;
`ifdef DECIM_ACC_AVG_EN
  logic signed [DW-1:0] out_avg;
`endif

  decim_accumulator #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .tick      (tick),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
`ifdef DECIM_ACC_AVG_EN
    .out_avg   (out_avg),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Window counter with en=1: carry-out on the last count of each window.
  logic [1:0] ctr_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= 2'd0;
    else        ctr_q <= ctr_q + 2'd1;
  end
  assign tick = (ctr_q == 2'd3);

  typedef struct {
    logic signed [31:0] sum;
    int                 cnt;
  } exp_t;

  typedef struct {
    logic [3:0]         vld;
    logic signed [7:0]  d [4];
    logic signed [31:0] sum;
    int                 cnt;
  } win_t;

  exp_t q[$];
  exp_t e;
  win_t tbl[7];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  function automatic win_t mk(input logic [3:0] v, input logic signed [7:0] a,
                              input logic signed [7:0] b, input logic signed [7:0] c,
                              input logic signed [7:0] f, input int s, input int n);
    win_t w;
    w.vld  = v;
    w.d[0] = a;
    w.d[1] = b;
    w.d[2] = c;
    w.d[3] = f;
    w.sum  = 32'(s);
    w.cnt  = n;
    return w;
  endfunction

  task automatic step(input logic v, input logic signed [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Step 0 is the MSB of vld/rdy so literals read left to right in time.
  task automatic run_window(input win_t w, input logic [3:0] rdy, input logic push);
    exp_t x;
    if (push) begin
      x.sum = w.sum;
      x.cnt = w.cnt;
      q.push_back(x);
    end
    for (int k = 0; k < 4; k++) step(w.vld[3-k], w.d[k], rdy[3-k]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  out_data,       0);
    chk({tag, "_out_cnt"},   32'(out_cnt),   0);
    chk({tag, "_overrun"},   32'(overrun),   0);
  endtask

  // Scoreboard: compare on every accepted handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_pending", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_out_data", out_data, e.sum);
        chk("sb_out_cnt", 32'(out_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    win_t w;
    tbl[0] = mk(4'b1111,    1,    2,    3,    4,   10, 4);
    tbl[1] = mk(4'b1111, -128, -128, -128, -128, -512, 4);
    tbl[2] = mk(4'b1111,  127,  127,  127,  127,  508, 4);
    tbl[3] = mk(4'b1010,    5,   99,    7,   -1,   12, 2);
    tbl[4] = mk(4'b0000,   11,   22,   33,   44,    0, 0);
    tbl[5] = mk(4'b0001,   50,   50,   50,   -3,   -3, 1);
    tbl[6] = mk(4'b1111,  100,  -50,   27,   -1,   76, 4);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table windows with the sink always ready.
    for (int i = 0; i < 7; i++) begin
      run_window(tbl[i], 4'b1111, 1'b1);
      chk("latency_out_valid", 32'(out_valid), 1);
      chk("tbl_overrun", 32'(overrun), 0);
    end

    // Ready coincides with tick while full: reload with no bubble.
    w = mk(4'b1111, 10, 20, 30, 40, 100, 4);
    run_window(w, 4'b0001, 1'b1);
    chk("simul_out_valid", 32'(out_valid), 1);
    chk("simul_out_data", out_data, 100);
    chk("simul_overrun", 32'(overrun), 0);

    // Backpressure across two ticks: second result dropped.
    w = mk(4'b1111, 1, 1, 1, 1, 4, 4);
    run_window(w, 4'b1000, 1'b1);
    step(1'b1, 8'sd2, 1'b0);
    chk("bp_hold_data", out_data, 4);
    chk("bp_hold_overrun", 32'(overrun), 0);
    step(1'b1, 8'sd2, 1'b0);
    step(1'b1, 8'sd2, 1'b0);
    step(1'b1, 8'sd2, 1'b0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_out_data", out_data, 4);
    chk("bp_out_cnt", 32'(out_cnt), 4);
    chk("bp_overrun", 32'(overrun), 1);
    e.sum = 12; e.cnt = 4;
    q.push_back(e);
    step(1'b1, 8'sd3, 1'b1);
    chk("bp_drain_out_valid", 32'(out_valid), 0);
    step(1'b1, 8'sd3, 1'b1);
    step(1'b1, 8'sd3, 1'b1);
    step(1'b1, 8'sd3, 1'b1);

    // Reset mid-window clears accumulation and sticky overrun.
    step(1'b1, 8'sd50, 1'b1);
    step(1'b1, 8'sd50, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w = mk(4'b1111, 6, 6, 6, 6, 24, 4);
    run_window(w, 4'b1111, 1'b1);
    chk("post_rst_overrun", 32'(overrun), 0);

    // Reset while a result is held: it is lost without overrun.
    w = mk(4'b1111, 1, 1, 1, 1, 4, 4);
    run_window(w, 4'b1000, 1'b0);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_out_data", out_data, 4);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_full");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w = mk(4'b1101, 7, 7, 99, 7, 21, 3);
    run_window(w, 4'b1111, 1'b1);
    step(1'b0, 8'sd0, 1'b1);
    step(1'b0, 8'sd0, 1'b1);
    chk("final_overrun", 32'(overrun), 0);
    chk("sb_drained", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
